// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data accesses take priority over instruction fetch.
// Optional access timeout is compiled in when ARB_TIMEOUT_EN is defined.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        if_ack,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDone} state_e;

    state_e state_q;
    logic   in_busy;
    logic   tmo_hit;

    assign in_busy = (state_q == StBusyI) || (state_q == StBusyD);

`ifdef ARB_TIMEOUT_EN
    logic [3:0] tmo_cnt_q;

    // Counter is zero on every BUSY entry because it is held clear while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= 4'd0;
        end else if (state_q == StIdle) begin
            tmo_cnt_q <= 4'd0;
        end else if (in_busy && !mem_ready) begin
            tmo_cnt_q <= tmo_cnt_q + 4'd1;
        end
    end

    assign tmo_hit = in_busy && (tmo_cnt_q == 4'd15) && !mem_ready;
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            rdata     <= 32'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (d_req) begin
                        state_q   <= StBusyD;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        busy      <= 1'b1;
                    end else if (if_req) begin
                        state_q   <= StBusyI;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= 32'd0;
                        busy      <= 1'b1;
                    end
                end
                StBusyI, StBusyD: begin
                    // Address and write data stay latched; requester inputs are ignored here.
                    if (mem_ready || tmo_hit) begin
                        state_q <= StDone;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        rdata   <= (mem_we || tmo_hit) ? 32'd0 : mem_rdata;
                        if_ack  <= (state_q == StBusyI);
                        d_ack   <= (state_q == StBusyD);
                        err     <= tmo_hit;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    mem_en  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed latency/reset cases, then randomized traffic checked by a
// scoreboard against a reference memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        if_ack;
    logic        d_ack;
    logic [31:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        err;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .if_ack    (if_ack),
        .d_ack     (d_ack),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    logic [31:0] mem_array[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    bit          mon_en      = 0;
    bit          hold_ready  = 0;
    int          fixed_waits = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem_array.exists(a) ? mem_array[a] : 32'd0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
    endfunction

    // Memory responder: decides mem_ready for the coming edge, with fixed or random wait states.
    initial begin
        bit in_access = 0;
        int wcnt = 0;
        int cur_waits = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_en && !hold_ready) begin
                if (!in_access) begin
                    in_access = 1;
                    wcnt = 0;
                    cur_waits = (fixed_waits >= 0) ? fixed_waits : int'($urandom_range(0, 4));
                end
                if (wcnt == cur_waits) begin
                    mem_ready = 1'b1;
                    in_access = 0;
                    if (mem_we) begin
                        mem_array[mem_addr] = mem_wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = rd(mem_addr);
                    end
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                if (!mem_en) in_access = 0;
            end
        end
    end

    // Scoreboard monitor: checks every access and every ack against the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (mem_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_access: mem_en=1 addr=0x%08h, expected no access",
                                 mem_addr);
                    end else begin
                        check("access_addr", mem_addr, exp_q[0].addr);
                        check("access_we", 32'(mem_we), 32'(exp_q[0].we));
                        if (exp_q[0].we) check("access_wdata", mem_wdata, exp_q[0].wdata);
                    end
                end
                if (if_ack || d_ack) begin
                    check("ack_exclusive", 32'(if_ack & d_ack), 32'd0);
                    check("en_low_in_done", 32'(mem_en), 32'd0);
                    check("err_low", 32'(err), 32'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b, expected none",
                                 if_ack, d_ack);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_kind", 32'(d_ack), 32'(e.is_d));
                        check("ack_rdata", rdata, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        int bad_busy;
        int bad_err;
        int op;
        int waited;
        bit drop_if;
        bit saw_ack;
        exp_t e;

        rst = 1'b1;
        if_req = 1'b1;
        d_req = 1'b1;
        if_addr = 32'h100;
        d_we = 1'b1;
        d_addr = 32'h200;
        d_wdata = 32'hFFFF_FFFF;
        fixed_waits = 0;
        for (int i = 0; i < 4; i++) begin
            mem_array[32'(i * 4)] = $urandom;
            ref_mem[32'(i * 4)] = mem_array[32'(i * 4)];
        end
        mem_array[32'h3000] = 32'h8C01_0004;
        mem_array[32'h20] = 32'h1234_5678;

        // Reset state: requests held high during reset must be ignored.
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_acks", 32'({if_ack, d_ack}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        if_req = 1'b0;
        d_req = 1'b0;
        rst = 1'b0;
        step();

        // Zero-wait fetch.
        if_addr = 32'h3000;
        if_req = 1'b1;
        step();
        check("f0_mem_en", 32'(mem_en), 32'd1);
        check("f0_mem_addr", mem_addr, 32'h3000);
        check("f0_mem_we", 32'(mem_we), 32'd0);
        check("f0_busy", 32'(busy), 32'd1);
        check("f0_no_ack_early", 32'(if_ack), 32'd0);
        step();
        check("f0_if_ack", 32'(if_ack), 32'd1);
        check("f0_rdata", rdata, 32'h8C01_0004);
        check("f0_en_done", 32'(mem_en), 32'd0);
        if_req = 1'b0;
        step();
        check("f0_ack_pulse", 32'(if_ack), 32'd0);
        check("f0_idle", 32'(busy), 32'd0);

        // Address latched for whole BUSY state despite requester change.
        fixed_waits = 2;
        if_addr = 32'h3000;
        if_req = 1'b1;
        step();
        if_addr = 32'h4000;
        step();
        check("hold_addr_1", mem_addr, 32'h3000);
        step();
        check("hold_addr_2", mem_addr, 32'h3000);
        check("hold_en", 32'(mem_en), 32'd1);
        step();
        check("hold_ack", 32'(if_ack), 32'd1);
        check("hold_rdata", rdata, 32'h8C01_0004);
        if_req = 1'b0;
        step();

        // Simultaneous store and fetch: store first.
        fixed_waits = 0;
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h10;
        d_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1;
        if_addr = 32'h3000;
        step();
        check("both_st_we", 32'(mem_we), 32'd1);
        check("both_st_addr", mem_addr, 32'h10);
        check("both_st_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        check("both_d_ack", 32'({d_ack, if_ack}), 32'b10);
        check("both_st_rdata", rdata, 32'd0);
        d_req = 1'b0;
        step();
        check("both_gap_en", 32'(mem_en), 32'd0);
        step();
        check("both_f_en", 32'(mem_en), 32'd1);
        check("both_f_addr", mem_addr, 32'h3000);
        check("both_f_we", 32'(mem_we), 32'd0);
        step();
        check("both_if_ack", 32'({d_ack, if_ack}), 32'b01);
        check("both_f_rdata", rdata, 32'h8C01_0004);
        if_req = 1'b0;
        check("both_mem_written", rd(32'h10), 32'hDEAD_BEEF);
        step();

        // Load with three wait states.
        fixed_waits = 3;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h20;
        step();
        for (int i = 0; i < 4; i++) begin
            check("ws_addr", mem_addr, 32'h20);
            check("ws_no_ack", 32'(d_ack), 32'd0);
            d_addr = 32'h999;
            step();
        end
        check("ws_d_ack", 32'(d_ack), 32'd1);
        check("ws_rdata", rdata, 32'h1234_5678);
        d_req = 1'b0;
        step();

        // Reset in the second BUSY_D cycle abandons the access.
        fixed_waits = 5;
        d_req = 1'b1;
        d_we = 1'b0;
        d_addr = 32'h20;
        step();
        step();
        rst = 1'b1;
        step();
        check("rb_busy", 32'(busy), 32'd0);
        check("rb_mem_en", 32'(mem_en), 32'd0);
        check("rb_rdata", rdata, 32'd0);
        rst = 1'b0;
        d_req = 1'b0;
        saw_ack = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (d_ack || mem_en) saw_ack = 1;
        end
        check("rb_no_ack", 32'(saw_ack), 32'd0);

        // Reload rdata so the timeout case shows it being cleared.
        fixed_waits = 0;
        if_addr = 32'h3000;
        if_req = 1'b1;
        step();
        step();
        check("pre_to_rdata", rdata, 32'h8C01_0004);
        if_req = 1'b0;
        step();

        // Memory never ready.
        hold_ready = 1;
        if_req = 1'b1;
        if_addr = 32'h3000;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) step();
        check("to_busy_16", 32'({busy, if_ack}), 32'b10);
        step();
        check("to_ack", 32'(if_ack), 32'd1);
        check("to_err", 32'(err), 32'd1);
        check("to_rdata", rdata, 32'd0);
        if_req = 1'b0;
        step();
        check("to_err_pulse", 32'(err), 32'd0);
        hold_ready = 0;
`else
        bad_busy = 0;
        bad_err = 0;
        step();
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b1) bad_busy++;
            if (err !== 1'b0) bad_err++;
            step();
        end
        check("nto_busy_cycles_bad", 32'(bad_busy), 32'd0);
        check("nto_err_cycles_bad", 32'(bad_err), 32'd0);
        if_req = 1'b0;
        hold_ready = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif
        step();

        // Randomized traffic against the reference model.
        fixed_waits = -1;
        mon_en = 1;
        for (int t = 0; t < 80; t++) begin
            op = int'($urandom_range(0, 2));
            drop_if = (op == 2) && ($urandom_range(0, 3) == 0);
            if (op != 0) begin
                d_we = 1'($urandom_range(0, 1));
                d_addr = {28'd0, 2'($urandom_range(0, 3)), 2'd0};
                d_wdata = $urandom;
                e.is_d = 1'b1;
                e.we = d_we;
                e.addr = d_addr;
                e.wdata = d_wdata;
                if (d_we) begin
                    ref_mem[d_addr] = d_wdata;
                    e.rdata = 32'd0;
                end else begin
                    e.rdata = ref_rd(d_addr);
                end
                exp_q.push_back(e);
                d_req = 1'b1;
            end
            if (op != 1) begin
                if_addr = {28'd0, 2'($urandom_range(0, 3)), 2'd0};
                if (!drop_if) begin
                    e.is_d = 1'b0;
                    e.we = 1'b0;
                    e.addr = if_addr;
                    e.wdata = 32'd0;
                    e.rdata = ref_rd(if_addr);
                    exp_q.push_back(e);
                end
                if_req = 1'b1;
            end
            waited = 0;
            do begin
                step();
                waited++;
                if (d_ack) d_req = 1'b0;
                if (if_ack) if_req = 1'b0;
                if (drop_if && waited == 1) if_req = 1'b0;
                d_addr = $urandom;
                d_wdata = $urandom;
                d_we = 1'($urandom_range(0, 1));
                if (op == 0) if_addr = $urandom;
            end while ((d_req || if_req) && waited < 200);
            if (d_req || if_req) begin
                checks++;
                failures++;
                $display("FAIL rand_timeout: no ack after %0d cycles, expected ack", waited);
                d_req = 1'b0;
                if_req = 1'b0;
            end
            repeat ($urandom_range(1, 3)) step();
        end
        repeat (3) step();
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL use one clock `clk`; `rst` is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 if_req  in  1  instruction-fetch request, held high until if_ack.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 d_req  in  1  data (lw/sw) request, held high until d_ack.
REQ-007 d_we  in  1  1 = store, 0 = load.
REQ-008 d_addr  in  32  data byte address.
REQ-009 d_wdata  in  32  store data.
REQ-010 if_ack  out  1  one-cycle completion pulse for fetch.
REQ-011 d_ack  out  1  one-cycle completion pulse for data access.
REQ-012 rdata  out  32  read data, valid in the ack cycle; shared by both requesters.
REQ-013 mem_en  out  1  memory access strobe.
REQ-014 mem_we  out  1  memory write enable.
REQ-015 mem_addr  out  32  memory address.
REQ-016 mem_wdata  out  32  memory write data.
REQ-017 mem_rdata  in  32  memory read data, valid when mem_ready=1.
REQ-018 mem_ready  in  1  memory completes the current access this cycle.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 err  out  1  timeout flag pulse, coincident with ack (see Configuration).

Function
REQ-021 SHALL implement states IDLE, BUSY_I, BUSY_D and DONE; all outputs SHALL be driven from registers.
REQ-022 IDLE: d_req=1 -> BUSY_D; else if_req=1 -> BUSY_I; else stay. Data SHALL have fixed priority over fetch.
REQ-023 On leaving IDLE, SHALL latch addr, we (fetch: we=0) and wdata; latched values SHALL hold on mem_* for the whole BUSY state, independent of later requester inputs.
REQ-024 BUSY_x: mem_en=1; mem_ready=0 -> stay (unbounded wait states); mem_ready=1 -> latch mem_rdata into rdata (stores latch 0) and go to DONE.
REQ-025 DONE: exactly one cycle; matching ack=1, mem_en=0, no new grant; then go to IDLE.
REQ-026 Zero-wait latency: request sampled in IDLE at cycle N -> mem_en in N+1 -> ack in N+2; each wait state adds one cycle.
REQ-027 rdata SHALL hold its last value until the next completion.
REQ-028 Simultaneous if_req and d_req: data is served first; fetch is granted in the IDLE cycle after data's DONE, provided if_req is still high.
REQ-029 A request deasserted before grant SHALL be dropped without a memory access; a request deasserted during BUSY SHALL NOT abort the access.
REQ-030 if_ack and d_ack SHALL never be high in the same cycle; mem_en SHALL never be high in DONE or IDLE.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE and clear rdata, latched addr/wdata/we, acks, err and timeout counter; all outputs SHALL read 0 in the following cycle.
REQ-032 Reset in BUSY_x SHALL abandon the access with no ack; requests present during reset SHALL be ignored until the first IDLE cycle after rst falls.

Configuration
REQ-033 Macro ARB_TIMEOUT_EN defined: a 4-bit counter SHALL clear on BUSY entry and increment each BUSY cycle with mem_ready=0; at 15 with mem_ready still 0, the block SHALL go to DONE with rdata=0, err=1 for that cycle and the normal ack.
REQ-034 ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely and err is tied to 0.

Verification
REQ-035 if_req=1, if_addr=0x00003000, mem_ready=1 always, mem_rdata=0x8C010004 -> mem_en at N+1 with addr 0x3000, we=0; if_ack=1 and rdata=0x8C010004 at N+2.
REQ-036 d_req and if_req both asserted at cycle N, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> store issued first (mem_we=1), d_ack at N+2, fetch mem_en at N+4, if_ack at N+5.
REQ-037 Load to 0x20 with 3 wait states (mem_ready high in 4th BUSY cycle), mem_rdata=0x12345678 -> d_ack at N+5 with rdata=0x12345678; mem_addr stable at 0x20 throughout.
REQ-038 rst=1 asserted during 2nd BUSY_D cycle -> next cycle busy=0, mem_en=0, rdata=0; no d_ack ever issued for that access.
REQ-039 ARB_TIMEOUT_EN defined, mem_ready held 0 -> DONE reached after 16 BUSY cycles with err=1, ack=1, rdata=0; undefined -> busy stays 1 and err stays 0 for 100 cycles.
REQ-040 Requester changes if_addr from 0x3000 to 0x4000 during BUSY_I -> mem_addr remains 0x3000 until DONE.
